// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing the command-driven single-port RAM between two
// word-level requesters; expands each access into the RAM's two-command sequence.
module ram_arbiter #(
   parameter int ADDR_SIZE  = 8,
   parameter int RD_TIMEOUT = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req0,
   input  logic                   req1,
   input  logic                   we0,
   input  logic                   we1,
   input  logic [ADDR_SIZE-1:0]   addr0,
   input  logic [ADDR_SIZE-1:0]   addr1,
   input  logic [ADDR_SIZE-1:0]   wdata0,
   input  logic [ADDR_SIZE-1:0]   wdata1,
   output logic                   ack0,
   output logic                   ack1,
   output logic [ADDR_SIZE-1:0]   rdata,
   output logic                   err,
   output logic                   busy,
   output logic                   rx_valid,
   output logic [ADDR_SIZE+1:0]   din,
   input  logic [ADDR_SIZE-1:0]   dout,
   input  logic                   tx_valid
);

   typedef enum logic [2:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA, RD_WAIT, DONE
   } state_t;

   localparam logic [3:0] TMO = 4'(RD_TIMEOUT);

   state_t                 state;
   logic                   last;
   logic                   gnt_id;
   logic [ADDR_SIZE-1:0]   addr_r;
   logic [ADDR_SIZE-1:0]   wdata_r;
   logic [3:0]             cnt;

   logic                   win;
   logic                   win_we;
   logic [ADDR_SIZE-1:0]   win_addr;
   logic [ADDR_SIZE-1:0]   win_wdata;

   // With both requesting, the one not served last wins; last resets to 1.
   always_comb begin
      win       = (req0 && req1) ? ~last : req1;
      win_we    = win ? we1 : we0;
      win_addr  = win ? addr1 : addr0;
      win_wdata = win ? wdata1 : wdata0;
   end

   // Outputs are loaded alongside the state they belong to, so every RAM port
   // comes straight from a flop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         last     <= 1'b1;
         gnt_id   <= 1'b0;
         addr_r   <= '0;
         wdata_r  <= '0;
         cnt      <= '0;
         rx_valid <= 1'b0;
         din      <= '0;
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         rdata    <= '0;
         err      <= 1'b0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  gnt_id   <= win;
                  addr_r   <= win_addr;
                  wdata_r  <= win_wdata;
                  busy     <= 1'b1;
                  rx_valid <= 1'b1;
                  if (win_we) begin
                     state <= WR_ADDR;
                     din   <= {2'b00, win_addr};
                  end else begin
                     state <= RD_ADDR;
                     din   <= {2'b10, win_addr};
                  end
               end
            end
            WR_ADDR: begin
               state <= WR_DATA;
               din   <= {2'b01, wdata_r};
            end
            WR_DATA: begin
               state    <= DONE;
               rx_valid <= 1'b0;
               din      <= '0;
               ack0     <= ~gnt_id;
               ack1     <= gnt_id;
               err      <= 1'b0;
            end
            RD_ADDR: begin
               state <= RD_DATA;
               din   <= {2'b11, {ADDR_SIZE{1'b0}}};
            end
            RD_DATA: begin
               state    <= RD_WAIT;
               rx_valid <= 1'b0;
               din      <= '0;
               cnt      <= '0;
            end
            RD_WAIT: begin
               if (!tx_valid) begin
                  cnt <= cnt + 4'd1;
               end
               if (tx_valid || (cnt + 4'd1) == TMO) begin
                  state <= DONE;
                  ack0  <= ~gnt_id;
                  ack1  <= gnt_id;
                  rdata <= tx_valid ? dout : '0;
                  err   <= ~tx_valid;
               end
            end
            DONE: begin
               state <= IDLE;
               ack0  <= 1'b0;
               ack1  <= 1'b0;
               err   <= 1'b0;
               busy  <= 1'b0;
               last  <= gnt_id;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, command/ack scoreboards, and one task
// per scenario.
module tb_ram_arbiter;

   localparam int AW  = 8;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [AW-1:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
   logic          ack0, ack1, err, busy, rx_valid;
   logic [AW-1:0] rdata;
   logic [AW+1:0] din;
   logic [AW-1:0] dout = '0;
   logic          tx_valid = 1'b0;

   always #5 clk = ~clk;

   ram_arbiter #(.ADDR_SIZE(AW), .RD_TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
      .rx_valid(rx_valid), .din(din), .dout(dout), .tx_valid(tx_valid)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural RAM: 00 wr addr, 01 wr data, 10 rd addr, 11 rd data.
   logic [AW-1:0] mem [256];
   logic [AW-1:0] ref_mem [256];
   logic [AW-1:0] wr_a = '0, rd_a = '0;
   bit            tx_block = 1'b0;

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]     = '0;
         ref_mem[i] = '0;
      end
   end

   always @(posedge clk) begin
      tx_valid <= 1'b0;
      if (rx_valid) begin
         case (din[AW+1:AW])
            2'b00: wr_a <= din[AW-1:0];
            2'b01: mem[wr_a] <= din[AW-1:0];
            2'b10: rd_a <= din[AW-1:0];
            2'b11: if (!tx_block) begin
               tx_valid <= 1'b1;
               dout     <= mem[rd_a];
            end
            default: ;
         endcase
      end
   end

   typedef struct {
      int            id;
      bit            we;
      logic [AW-1:0] rdata;
      bit            err;
   } exp_t;

   exp_t          sb_q[$];
   logic [AW+1:0] cmd_q[$];

   task automatic push_exp(input int id, input bit we, input logic [AW-1:0] a,
                           input logic [AW-1:0] d);
      exp_t e;
      e.id = id; e.we = we; e.err = 1'b0; e.rdata = '0;
      if (we) begin
         cmd_q.push_back({2'b00, a});
         cmd_q.push_back({2'b01, d});
         ref_mem[a] = d;
      end else begin
         cmd_q.push_back({2'b10, a});
         cmd_q.push_back(10'h300);
         if (tx_block) e.err = 1'b1;
         else e.rdata = ref_mem[a];
      end
      sb_q.push_back(e);
   endtask

   task automatic set_req(input int id, input bit we, input logic [AW-1:0] a,
                          input logic [AW-1:0] d);
      if (id == 0) begin
         req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
      end else begin
         req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
      end
   endtask

   // Returns the cycle index of the ack (request driven in cycle 0), or -1.
   task automatic wait_ack(input int id, output int lat);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if ((id == 0 && ack0 === 1'b1) || (id == 1 && ack1 === 1'b1)) begin
            lat = k;
            if (id == 0) req0 = 1'b0;
            else req1 = 1'b0;
            break;
         end
      end
   endtask

   // Monitors: every RAM command against the expected stream, every ack
   // against the transaction scoreboard, idle-cycle din/err at zero.
   logic [AW+1:0] mon_cmd;
   exp_t          mon_e;
   bit            prev_a0 = 1'b0, prev_a1 = 1'b0;
   int            got_id;

   always @(negedge clk) begin
      n_checks++;
      if (rx_valid === 1'b1) begin
         if (cmd_q.size() == 0) begin
            $display("FAIL cmd_unexpected: din=%h, expected no command", din);
         end else begin
            mon_cmd = cmd_q.pop_front();
            if (din !== mon_cmd) $display("FAIL cmd_word: din=%h expected %h", din, mon_cmd);
            else n_pass++;
         end
      end else begin
         if (rx_valid !== 1'b0 || din !== '0)
            $display("FAIL cmd_idle: rx_valid=%b din=%h expected 0/000", rx_valid, din);
         else n_pass++;
      end

      n_checks++;
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
         got_id = (ack1 === 1'b1) ? 1 : 0;
         if (sb_q.size() == 0) begin
            $display("FAIL ack_unexpected: ack0=%b ack1=%b, expected none", ack0, ack1);
         end else begin
            mon_e = sb_q.pop_front();
            if ((ack0 === 1'b1 && ack1 === 1'b1) || got_id != mon_e.id || err !== mon_e.err ||
                (!mon_e.we && rdata !== mon_e.rdata) ||
                (ack0 === 1'b1 && prev_a0) || (ack1 === 1'b1 && prev_a1))
               $display("FAIL ack_sb: id=%0d err=%b rdata=%h expected id=%0d err=%b rdata=%h",
                        got_id, err, rdata, mon_e.id, mon_e.err, mon_e.rdata);
            else n_pass++;
         end
      end else begin
         if (err !== 1'b0) $display("FAIL err_idle: err=%b expected 0", err);
         else n_pass++;
      end
      prev_a0 = (ack0 === 1'b1);
      prev_a1 = (ack1 === 1'b1);
   end

   task automatic test_reset();
      int lat;
      rst_n = 1'b0;
      set_req(0, 1'b1, 8'h05, 8'h55);
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if ({rx_valid, din, ack0, ack1, rdata, err, busy} !== '0)
            $display("FAIL reset_outputs: got %h expected 0",
                     {rx_valid, din, ack0, ack1, rdata, err, busy});
         else n_pass++;
      end
      rst_n = 1'b1;
      push_exp(0, 1'b1, 8'h05, 8'h55);
      wait_ack(0, lat);
      n_checks++;
      if (lat !== 3) $display("FAIL reset_first_grant: ack cycle %0d expected 3", lat);
      else n_pass++;
   endtask

   task automatic test_write();
      int lat = -1;
      @(negedge clk);
      set_req(0, 1'b1, 8'h3C, 8'hA5);
      push_exp(0, 1'b1, 8'h3C, 8'hA5);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (ack0 === 1'b1) begin
            lat = k;
            req0 = 1'b0;
            break;
         end
         n_checks++;
         if (busy !== 1'b1) $display("FAIL write_busy: cycle %0d busy=%b expected 1", k, busy);
         else n_pass++;
      end
      n_checks++;
      if (lat !== 3) $display("FAIL write_latency: ack cycle %0d expected 3", lat);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || ack0 !== 1'b0)
         $display("FAIL write_after: busy=%b ack0=%b expected 0/0", busy, ack0);
      else n_pass++;
      n_checks++;
      if (mem[8'h3C] !== 8'hA5) $display("FAIL write_ram: mem[3C]=%h expected a5", mem[8'h3C]);
      else n_pass++;
   endtask

   task automatic test_read();
      int lat;
      @(negedge clk);
      set_req(1, 1'b0, 8'h3C, 8'h00);
      push_exp(1, 1'b0, 8'h3C, 8'h00);
      wait_ack(1, lat);
      n_checks++;
      if (lat !== 4 || rdata !== 8'hA5 || err !== 1'b0)
         $display("FAIL read_basic: cycle %0d rdata=%h err=%b expected 4/a5/0", lat, rdata, err);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (rdata !== 8'hA5) $display("FAIL read_hold: rdata=%h expected a5", rdata);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      int order[4];
      int at[4];
      int n = 0, c0 = 0, c1 = 0;
      int exp_at[4] = '{3, 8, 12, 17};
      @(negedge clk);
      set_req(0, 1'b1, 8'h10, 8'h11);
      set_req(1, 1'b0, 8'h3C, 8'h00);
      push_exp(0, 1'b1, 8'h10, 8'h11);
      push_exp(1, 1'b0, 8'h3C, 8'h00);
      push_exp(0, 1'b1, 8'h10, 8'h11);
      push_exp(1, 1'b0, 8'h3C, 8'h00);
      for (int k = 1; k <= 60 && n < 4; k++) begin
         @(negedge clk);
         if (ack0 === 1'b1 || ack1 === 1'b1) begin
            order[n] = (ack1 === 1'b1) ? 1 : 0;
            at[n]    = k;
            n++;
            if (ack0 === 1'b1 && ++c0 == 2) req0 = 1'b0;
            if (ack1 === 1'b1 && ++c1 == 2) req1 = 1'b0;
         end
      end
      n_checks++;
      if (n !== 4) $display("FAIL rr_count: %0d acks expected 4", n);
      else n_pass++;
      for (int i = 0; i < n; i++) begin
         n_checks++;
         if (order[i] !== (i % 2) || at[i] !== exp_at[i])
            $display("FAIL rr_grant%0d: id=%0d cycle=%0d expected id=%0d cycle=%0d",
                     i, order[i], at[i], i % 2, exp_at[i]);
         else n_pass++;
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) $display("FAIL rr_idle: busy=%b expected 0", busy);
      else n_pass++;
   endtask

   task automatic test_timeout();
      int lat;
      @(negedge clk);
      tx_block = 1'b1;
      set_req(0, 1'b0, 8'h3C, 8'h00);
      push_exp(0, 1'b0, 8'h3C, 8'h00);
      wait_ack(0, lat);
      tx_block = 1'b0;
      n_checks++;
      if (lat !== 3 + TMO || err !== 1'b1 || rdata !== 8'h00)
         $display("FAIL timeout: cycle %0d err=%b rdata=%h expected %0d/1/00",
                  lat, err, rdata, 3 + TMO);
      else n_pass++;
      @(negedge clk);
      set_req(1, 1'b0, 8'h10, 8'h00);
      push_exp(1, 1'b0, 8'h10, 8'h00);
      wait_ack(1, lat);
      n_checks++;
      if (lat !== 4 || err !== 1'b0 || rdata !== 8'h11)
         $display("FAIL timeout_recover: cycle %0d err=%b rdata=%h expected 4/0/11",
                  lat, err, rdata);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int lat;
      @(negedge clk);
      set_req(0, 1'b1, 8'h20, 8'h22);
      set_req(1, 1'b0, 8'h20, 8'h00);
      cmd_q.push_back(10'h020);
      cmd_q.push_back(10'h122);
      ref_mem[8'h20] = 8'h22;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (din !== 10'h122) $display("FAIL mid_wr_data: din=%h expected 122", din);
      else n_pass++;
      rst_n = 1'b0;
      req0  = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({ack0, ack1, busy, rx_valid, din, rdata, err} !== '0)
         $display("FAIL mid_reset: got %h expected 0", {ack0, ack1, busy, rx_valid, din, rdata, err});
      else n_pass++;
      rst_n = 1'b1;
      push_exp(1, 1'b0, 8'h20, 8'h00);
      wait_ack(1, lat);
      n_checks++;
      if (lat !== 4 || rdata !== 8'h22)
         $display("FAIL mid_regrant: cycle %0d rdata=%h expected 4/22", lat, rdata);
      else n_pass++;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation exceeded time limit, expected completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write();
      test_read();
      test_round_robin();
      test_timeout();
      test_reset_mid();
      repeat (3) @(negedge clk);
      n_checks++;
      if (sb_q.size() != 0 || cmd_q.size() != 0)
         $display("FAIL drain: %0d acks and %0d commands outstanding, expected 0/0",
                  sb_q.size(), cmd_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
